// File: rtl/spi_pkg.sv
// spi_pkg: packet layout and FSM state encoding shared by the SPI master and receiver.
package spi_pkg;
    localparam int PACKET_W = 24;
    localparam int CMD_MSB  = 23;
    localparam int CMD_LSB  = 16;
    localparam int VAL_MSB  = 15;
    localparam int VAL_LSB  = 0;

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter timing each FSM phase; tc_o flags the last cycle.
module spi_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         tc_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (load_i)
            count_q <= val_i;
        else if (count_q != '0)
            count_q <= count_q - W'(1);
    end

    assign tc_o = count_q == '0;
endmodule

// File: rtl/spi_packet_master.sv
// spi_packet_master: serializes one WIDTH-bit packet per handshake onto cs/sck/sdi, MSB first.
module spi_packet_master
    import spi_pkg::*;
#(
    parameter int WIDTH    = PACKET_W,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             cs,
    output logic             sck,
    output logic             sdi
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);

    spi_state_t       state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BW-1:0]    bit_q;
    logic             ready_q, busy_q, done_q, cs_q, sck_q, sdi_q;
    logic             tc, handshake, phase_load;
    logic [PW-1:0]    phase_val;

    assign handshake  = tx_valid && ready_q;
    // The timer reloads on every state change, so each phase sees a fresh count.
    assign phase_load = (state_q == IDLE) ? handshake : (state_q == DONE) || tc;
    assign phase_val  = (state_q == IDLE) ? PW'(CS_SETUP - 1) :
                        (state_q == HIGH && bit_q == '0) ? PW'(CS_HOLD - 1) : PW'(CLK_DIV - 1);

    spi_phase_timer #(.W(PW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load_i(phase_load),
        .val_i (phase_val),
        .tc_o  (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (handshake) begin
                    shift_q <= tx_data;
                    bit_q   <= BW'(WIDTH - 1);
                    sdi_q   <= tx_data[WIDTH-1];
                    cs_q    <= 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= SETUP;
                end
                SETUP: if (tc) state_q <= LOW;
                LOW: if (tc) begin
                    sck_q   <= 1'b1;
                    state_q <= HIGH;
                end
                HIGH: if (tc) begin
                    sck_q <= 1'b0;
                    if (bit_q == '0) begin
                        state_q <= HOLD;
                    end else begin
                        // Next bit goes out on the same edge that drops sck.
                        shift_q <= shift_q << 1;
                        sdi_q   <= shift_q[WIDTH-2];
                        bit_q   <= bit_q - BW'(1);
                        state_q <= LOW;
                    end
                end
                HOLD: if (tc) begin
                    cs_q    <= 1'b0;
                    sdi_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cs       = cs_q;
    assign sck      = sck_q;
    assign sdi      = sdi_q;
endmodule

// File: tb/tb_spi_packet_master.sv
// tb_spi_packet_master: default and fast instances share stimulus; each is checked every cycle
// against a waveform computed from its frame timing, plus a bit-capturing receiver.
module tb_spi_packet_master;
    import spi_pkg::*;

    localparam int W  = 24;
    localparam int SA = 2, CA = 4, HA = 2;
    localparam int SB = 1, CB = 1, HB = 1;
    localparam int DA = SA + 2 * CA * W + HA;
    localparam int DB = SB + 2 * CB * W + HB;

    logic clk = 1'b0, reset = 1'b1, tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic ready_a, busy_a, done_a, cs_a, sck_a, sdi_a;
    logic ready_b, busy_b, done_b, cs_b, sck_b, sdi_b;
    int total = 0, passed = 0, cyc = 0, hs = 0;
    int ka = -1, kb = -1;
    logic [W-1:0] da = '0, db = '0;
    bit started = 0;

    always #5 clk = ~clk;

    spi_packet_master #(.WIDTH(W), .CLK_DIV(CA), .CS_SETUP(SA), .CS_HOLD(HA)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready_a),
        .busy(busy_a), .done(done_a), .cs(cs_a), .sck(sck_a), .sdi(sdi_a));

    spi_packet_master #(.WIDTH(W), .CLK_DIV(CB), .CS_SETUP(SB), .CS_HOLD(HB)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready_b),
        .busy(busy_b), .done(done_b), .cs(cs_b), .sck(sck_b), .sdi(sdi_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected {tx_ready, busy, done, cs, sck, sdi} k cycles after the handshake edge (k<0: idle).
    function automatic logic [5:0] exp_out(input int k, input logic [W-1:0] d,
                                           input int su, input int cd, input int ho);
        int dur, j;
        logic s, b;
        dur = su + 2 * cd * W + ho;
        if (k < 0) return 6'b100000;
        if (k == dur + 1) return 6'b011000;
        j = k - 1 - su;
        if (j < 0) begin
            s = 1'b0; b = d[W-1];
        end else if (j >= 2 * cd * W) begin
            s = 1'b0; b = d[0];
        end else begin
            s = (j % (2 * cd)) >= cd;
            b = d[W-1-j/(2*cd)];
        end
        return {4'b0101, s, b};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            ka = -1; kb = -1; started = 1;
        end else begin
            if (ka < 0) begin
                if (tx_valid) begin ka = 1; da = tx_data; end
            end else ka = (ka == DA + 1) ? -1 : ka + 1;
            if (kb < 0) begin
                if (tx_valid) begin kb = 1; db = tx_data; end
            end else kb = (kb == DB + 1) ? -1 : kb + 1;
        end
    end

    int ra = 0, la = 0, lowa = 0, gap_a = 0, lr_a = 0, ll_a = 0, dones_a = 0, done_cyc_a = 0;
    int rb = 0, lb = 0, lr_b = 0, ll_b = 0;
    logic [W-1:0] wa = '0, lw_a = '0, wb = '0, lw_b = '0;
    logic psck_a = 0, pcs_a = 0, psdi_a = 0, psck_b = 0, pcs_b = 0, psdi_b = 0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("out_a", {ready_a, busy_a, done_a, cs_a, sck_a, sdi_a}, exp_out(ka, da, SA, CA, HA));
            check("out_b", {ready_b, busy_b, done_b, cs_b, sck_b, sdi_b}, exp_out(kb, db, SB, CB, HB));
            check("proto_a", {sck_a & ~cs_a, psck_a & sck_a & (sdi_a ^ psdi_a)}, 0);
            check("proto_b", {sck_b & ~cs_b, psck_b & sck_b & (sdi_b ^ psdi_b)}, 0);
            if (sck_a && !psck_a) begin wa = {wa[W-2:0], sdi_a}; ra++; end
            if (sck_b && !psck_b) begin wb = {wb[W-2:0], sdi_b}; rb++; end
            if (cs_a) la++; else lowa++;
            if (cs_b) lb++;
            if (cs_a && !pcs_a) begin gap_a = lowa; lowa = 0; end
            if (!cs_a && pcs_a && ka == DA + 1) begin
                check("word_a", wa, da);
                check("rises_a", ra, W);
                check("cslen_a", la, DA);
                lw_a = wa; lr_a = ra; ll_a = la;
            end
            if (!cs_b && pcs_b && kb == DB + 1) begin
                check("word_b", wb, db);
                check("rises_b", rb, W);
                check("cslen_b", lb, DB);
                lw_b = wb; lr_b = rb; ll_b = lb;
            end
            if (!cs_a) begin ra = 0; la = 0; end
            if (!cs_b) begin rb = 0; lb = 0; end
            if (done_a) begin dones_a++; done_cyc_a = cyc; end
        end
        psck_a = sck_a; pcs_a = cs_a; psdi_a = sdi_a;
        psck_b = sck_b; pcs_b = cs_b; psdi_b = sdi_b;
    end

    task automatic send(input logic [W-1:0] d);
        @(negedge clk); #1;
        tx_data = d; tx_valid = 1'b1; hs = cyc;
        @(negedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk); #1;
            if (which ? done_b : done_a) return;
        end
        check("done_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        check("reset_a", {ready_a, busy_a, done_a, cs_a, sck_a, sdi_a}, 6'b100000);
        check("reset_b", {ready_b, busy_b, done_b, cs_b, sck_b, sdi_b}, 6'b100000);

        send(24'h0114ff);
        wait_done(0, 400);
        check("len1", ll_a, 196);
        check("word1", lw_a, 24'h0114ff);
        check("cmd1", lw_a[CMD_MSB:CMD_LSB], 8'h01);
        check("val1", lw_a[VAL_MSB:VAL_LSB], 16'h14ff);
        check("rises1", lr_a, 24);
        check("latency1", done_cyc_a - hs, 197);

        send(24'h800001);
        wait_done(1, 100);
        check("len_fast", ll_b, 50);
        check("word_fast", lw_b, 24'h800001);
        check("rises_fast", lr_b, 24);
        wait_done(0, 400);

        @(negedge clk); #1;
        tx_data = 24'hA5A5A5; tx_valid = 1'b1;
        for (int n = 0; n < 10 && ka != 1; n++) begin @(negedge clk); #1; end
        tx_data = 24'h5A5A5A;
        wait_done(0, 400);
        check("b2b_first", lw_a, 24'hA5A5A5);
        wait_done(0, 400);
        tx_valid = 1'b0;
        check("b2b_second", lw_a, 24'h5A5A5A);
        check("b2b_gap", gap_a, 2);

        d0 = dones_a;
        send(24'h000001);
        repeat (50) @(negedge clk);
        #1 tx_data = 24'hFFFFFF; tx_valid = 1'b1;
        @(negedge clk); #1 tx_valid = 1'b0;
        wait_done(0, 400);
        repeat (5) @(negedge clk);
        check("midchange_word", lw_a, 24'h000001);
        check("midchange_dones", dones_a - d0, 1);

        send(24'hABCDEF);
        for (int n = 0; n < 400 && ra != 10; n++) begin @(negedge clk); #1; end
        check("abort_reached", ra, 10);
        d0 = dones_a;
        reset = 1'b1;
        @(negedge clk); #1;
        check("abort_lines", {done_a, cs_a, sck_a, sdi_a}, 4'b0000);
        reset = 1'b0;
        @(negedge clk); #1;
        check("abort_ready", ready_a, 1);
        check("abort_nodone", dones_a - d0, 0);
        send(24'h123456);
        wait_done(0, 400);
        check("after_abort", lw_a, 24'h123456);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk); #1;
            tx_valid = $urandom_range(0, 3) == 0;
            tx_data  = W'($urandom);
            reset    = $urandom_range(0, 599) == 0;
        end
        @(negedge clk); #1;
        reset = 1'b0; tx_valid = 1'b0;
        repeat (450) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
